// File: rtl/fp_addsub_normalize_stage.sv
// ---------------------------------------------------------------------------
// fp_addsub_normalize_stage
//
// Stage 4 of the floating-point add/sub datapath. Normalizes the raw aligned
// sum/difference from the mantissa adder, adjusts the exponent, folds the
// shifted-out bits into sticky, takes the round-to-nearest-even decision and
// registers the result behind a valid/ready handshake for the rounding stage.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   InValid / InReady     upstream handshake
//   RawSum                [27]=carry, [26:3]=mantissa, [2]=G, [1]=R, [0]=S
//   ExponentIn, SignIn    exponent before normalization, result sign
//   OutValid / OutReady   downstream handshake
//   TobeRounded, Round    normalized mantissa and round-increment decision
//   ExponentAdderResult1  adjusted exponent
//   SignOut               registered sign
//   Zero, Underflow, Overflow  result flags
//
// Build option:
//   NORM_SKID_BUF_EN  adds a one-entry skid buffer; InReady becomes the
//                     registered "skid buffer empty" flag. Without it a single
//                     output register is used and InReady is combinational.
// ---------------------------------------------------------------------------
module fp_addsub_normalize_stage #(
  parameter int FractionSize = 23,
  parameter int MantissaSize = FractionSize + 1,
  parameter int RawSize      = MantissaSize + 4,
  parameter int ExponentSize = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [RawSize-1:0]      RawSum,
  input  logic [ExponentSize-1:0] ExponentIn,
  input  logic                    SignIn,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [MantissaSize-1:0] TobeRounded,
  output logic                    Round,
  output logic [ExponentSize-1:0] ExponentAdderResult1,
  output logic                    SignOut,
  output logic                    Zero,
  output logic                    Underflow,
  output logic                    Overflow
);

  localparam int BodySize = RawSize - 1;          // RawSum without the carry bit
  localparam int LzWidth  = $clog2(BodySize);
  localparam int ResSize  = MantissaSize + ExponentSize + 5;

  logic [BodySize-1:0]     w_body;
  logic [LzWidth-1:0]      w_lz;
  logic [ExponentSize:0]   w_exp_inc;
  logic [BodySize-1:0]     w_shifted;
  logic [ExponentSize-1:0] w_exp;
  logic [ExponentSize-1:0] w_shamt;
  logic                    w_zero;
  logic                    w_uf;
  logic                    w_of;
  logic                    w_round;
  logic [ResSize-1:0]      w_result;

  logic [ResSize-1:0]      r_out;
  logic                    r_valid;

  assign w_body    = RawSum[BodySize-1:0];
  assign w_exp_inc = {1'b0, ExponentIn} + (ExponentSize+1)'(1);

  // Leading-zero count of the body; higher set bits overwrite lower ones so
  // the most significant one wins.
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < BodySize; i++) begin
      if (RawSum[i]) w_lz = LzWidth'(BodySize - 1 - i);
    end
  end

  always_comb begin
    w_shifted = '0;
    w_exp     = '0;
    w_shamt   = '0;
    w_zero    = 1'b0;
    w_uf      = 1'b0;
    w_of      = 1'b0;
    if (RawSum == '0) begin
      w_zero = 1'b1;
    end else if (RawSum[RawSize-1]) begin
      // Carry out: shift right one, old R and S collapse into the new sticky.
      w_shifted = {RawSum[RawSize-1:2], RawSum[1] | RawSum[0]};
      if (w_exp_inc >= {1'b0, {ExponentSize{1'b1}}}) begin
        w_of  = 1'b1;
        w_exp = '1;
      end else begin
        w_exp = w_exp_inc[ExponentSize-1:0];
      end
    end else if (ExponentSize'(w_lz) < ExponentIn) begin
      w_shifted = w_body << w_lz;
      w_exp     = ExponentIn - ExponentSize'(w_lz);
    end else begin
      // Cannot fully normalize: shift only as far as the exponent allows and
      // emit a denormal with a zero exponent.
      w_shamt   = (ExponentIn == '0) ? '0 : ExponentIn - ExponentSize'(1);
      w_shifted = w_body << w_shamt;
      w_uf      = 1'b1;
    end
  end

  // RNE: increment when G is set and the value is above the halfway point
  // (R|S) or exactly halfway with an odd LSB (L).
  assign w_round = w_shifted[2] & (w_shifted[1] | w_shifted[0] | w_shifted[3]) & ~w_of;

  assign w_result = {SignIn, w_zero, w_uf, w_of, w_round, w_exp,
                     w_shifted[BodySize-1:3]};

`ifdef NORM_SKID_BUF_EN
  logic [ResSize-1:0] r_skid;
  logic               r_skid_valid;

  assign InReady = !r_skid_valid;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (!r_valid || OutReady) begin
      // Output register free this cycle: the skid entry is older, so it goes
      // first (InReady is low whenever the skid entry is occupied).
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_valid      <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (InValid) begin
        r_out   <= w_result;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (InValid && !r_skid_valid) begin
      r_skid       <= w_result;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign InReady = !r_valid || OutReady;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (InValid && InReady) begin
      r_out   <= w_result;
      r_valid <= 1'b1;
    end else if (OutReady) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign OutValid             = r_valid;
  assign SignOut              = r_out[ResSize-1];
  assign Zero                 = r_out[ResSize-2];
  assign Underflow            = r_out[ResSize-3];
  assign Overflow             = r_out[ResSize-4];
  assign Round                = r_out[ResSize-5];
  assign ExponentAdderResult1 = r_out[MantissaSize +: ExponentSize];
  assign TobeRounded          = r_out[MantissaSize-1:0];

endmodule

// File: tb/tb_fp_addsub_normalize_stage.sv
module tb_fp_addsub_normalize_stage;

  logic        Clk;
  logic        Reset_n;
  logic        InValid;
  logic        InReady;
  logic [27:0] RawSum;
  logic [7:0]  ExponentIn;
  logic        SignIn;
  logic        OutValid;
  logic        OutReady;
  logic [23:0] TobeRounded;
  logic        Round;
  logic [7:0]  ExponentAdderResult1;
  logic        SignOut;
  logic        Zero;
  logic        Underflow;
  logic        Overflow;

  fp_addsub_normalize_stage dut (
    .Clk                  (Clk),
    .Reset_n              (Reset_n),
    .InValid              (InValid),
    .InReady              (InReady),
    .RawSum               (RawSum),
    .ExponentIn           (ExponentIn),
    .SignIn               (SignIn),
    .OutValid             (OutValid),
    .OutReady             (OutReady),
    .TobeRounded          (TobeRounded),
    .Round                (Round),
    .ExponentAdderResult1 (ExponentAdderResult1),
    .SignOut              (SignOut),
    .Zero                 (Zero),
    .Underflow            (Underflow),
    .Overflow             (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output bundle: {sign, zero, uf, of, round, exponent[7:0], mantissa[23:0]}
  logic [36:0] w_out;
  assign w_out = {SignOut, Zero, Underflow, Overflow, Round, ExponentAdderResult1, TobeRounded};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [27:0] raw;
    logic [7:0]  e;
    logic        s;
    logic [36:0] exp_out;
  } vec_t;

  vec_t        tbl[15];
  logic [36:0] q[$];
  logic [36:0] held;
  logic [36:0] m_a, m_b, m_c;
  logic        have_hold;
  logic        iv, ordy, rs;
  logic [27:0] rraw;
  logic [7:0]  re;
  logic [31:0] rword;

  function automatic logic [36:0] pack(input logic s, input logic z, input logic uf,
                                       input logic of, input logic rnd, input logic [7:0] ex,
                                       input logic [23:0] m);
    return {s, z, uf, of, rnd, ex, m};
  endfunction

  // Reference: value-level description of normalization and RNE.
  function automatic logic [36:0] model(input logic [27:0] raw, input logic [7:0] e,
                                        input logic s);
    int unsigned v;
    int ex, lz, p;
    logic uf, of, rnd;
    uf = 1'b0;
    of = 1'b0;
    v  = 0;
    ex = 0;
    if (raw == 28'd0) return {s, 1'b1, 35'd0};
    if (raw >= 28'h8000000) begin
      v  = (32'(raw) >> 1) | (32'(raw) & 32'd1);
      ex = int'(e) + 1;
      if (ex >= 255) begin
        of = 1'b1;
        ex = 255;
      end
    end else begin
      p = 26;
      while (raw[p] == 1'b0) p--;
      lz = 26 - p;
      if (lz < int'(e)) begin
        v  = 32'(raw) << lz;
        ex = int'(e) - lz;
      end else begin
        v  = 32'(raw) << ((e > 0) ? int'(e) - 1 : 0);
        ex = 0;
        uf = 1'b1;
      end
    end
    rnd = v[2] && (v[1] || v[0] || v[3]) && !of;
    return {s, 1'b0, uf, of, rnd, 8'(ex), 24'(v >> 3)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive inputs just after a rising edge, then advance to mid-cycle for checks.
  task automatic cyc(input logic v, input logic [27:0] raw, input logic [7:0] e,
                     input logic s, input logic ordy_i);
    InValid    = v;
    RawSum     = raw;
    ExponentIn = e;
    SignIn     = s;
    OutReady   = ordy_i;
    #4;
  endtask

  task automatic next_edge();
    @(posedge Clk);
    #1;
  endtask

  // Random-phase per-cycle scoreboard step, called at mid-cycle.
  task automatic score();
    if (have_hold) chk("hold_stable", 64'({OutValid, w_out}), 64'({1'b1, held}));
    have_hold = OutValid && !OutReady;
    held      = w_out;
    if (OutValid && OutReady) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rand_out: actual=%h required=<no output pending>", w_out);
      end else begin
        chk("rand_out", 64'(w_out), 64'(q.pop_front()));
      end
    end
    if (InValid && InReady) q.push_back(model(RawSum, ExponentIn, SignIn));
  endtask

  initial begin
    tbl[0]  = '{28'h8000000, 8'd127, 1'b0, pack(0, 0, 0, 0, 0, 8'd128, 24'h800000)};
    tbl[1]  = '{28'h0000008, 8'd100, 1'b1, pack(1, 0, 0, 0, 0, 8'd77,  24'h800000)};
    tbl[2]  = '{28'h0000000, 8'd100, 1'b1, pack(1, 1, 0, 0, 0, 8'd0,   24'h000000)};
    tbl[3]  = '{28'h4000004, 8'd127, 1'b0, pack(0, 0, 0, 0, 0, 8'd127, 24'h800000)};
    tbl[4]  = '{28'h400000C, 8'd127, 1'b0, pack(0, 0, 0, 0, 1, 8'd127, 24'h800001)};
    tbl[5]  = '{28'h4000006, 8'd127, 1'b1, pack(1, 0, 0, 0, 1, 8'd127, 24'h800000)};
    tbl[6]  = '{28'h0000008, 8'd5,   1'b0, pack(0, 0, 1, 0, 0, 8'd0,   24'h000010)};
    tbl[7]  = '{28'h8000000, 8'd254, 1'b0, pack(0, 0, 0, 1, 0, 8'd255, 24'h800000)};
    tbl[8]  = '{28'h800000C, 8'd10,  1'b0, pack(0, 0, 0, 0, 1, 8'd11,  24'h800000)};
    tbl[9]  = '{28'h800000C, 8'd254, 1'b1, pack(1, 0, 0, 1, 0, 8'd255, 24'h800000)};
    tbl[10] = '{28'h4000000, 8'd0,   1'b0, pack(0, 0, 1, 0, 0, 8'd0,   24'h800000)};
    tbl[11] = '{28'h0000008, 8'd23,  1'b0, pack(0, 0, 1, 0, 0, 8'd0,   24'h400000)};
    tbl[12] = '{28'h0000008, 8'd24,  1'b0, pack(0, 0, 0, 0, 0, 8'd1,   24'h800000)};
    tbl[13] = '{28'h0000001, 8'd100, 1'b0, pack(0, 0, 0, 0, 0, 8'd74,  24'h800000)};
    tbl[14] = '{28'h8000009, 8'd50,  1'b1, pack(1, 0, 0, 0, 1, 8'd51,  24'h800000)};

    Reset_n    = 1'b0;
    InValid    = 1'b0;
    RawSum     = '0;
    ExponentIn = '0;
    SignIn     = 1'b0;
    OutReady   = 1'b0;
    have_hold  = 1'b0;
    held       = '0;
    #3;
    chk("reset_state", 64'({OutValid, w_out}), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    next_edge();

    // Directed vectors, one transfer each with the output always consumed.
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, tbl[i].raw, tbl[i].e, tbl[i].s, 1'b1);
      next_edge();
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      chk($sformatf("vec%0d", i), 64'({OutValid, w_out}), 64'({1'b1, tbl[i].exp_out}));
      next_edge();
    end

    // Backpressure: A stalled for three cycles while B is offered.
    m_a = model(28'h4000006, 8'd127, 1'b0);
    m_b = model(28'h0000008, 8'd100, 1'b1);
    cyc(1'b1, 28'h4000006, 8'd127, 1'b0, 1'b0);
    chk("bp_ready_c0", 64'(InReady), 64'd1);
    next_edge();
    for (int c = 1; c <= 3; c++) begin
      cyc(1'b1, 28'h0000008, 8'd100, 1'b1, 1'b0);
      chk($sformatf("bp_hold_c%0d", c), 64'({OutValid, w_out}), 64'({1'b1, m_a}));
`ifdef NORM_SKID_BUF_EN
      chk($sformatf("bp_ready_c%0d", c), 64'(InReady), (c == 1) ? 64'd1 : 64'd0);
`else
      chk($sformatf("bp_ready_c%0d", c), 64'(InReady), 64'd0);
`endif
      next_edge();
    end
    cyc(1'b1, 28'h0000008, 8'd100, 1'b1, 1'b1);
    chk("bp_a_out", 64'({OutValid, w_out}), 64'({1'b1, m_a}));
`ifdef NORM_SKID_BUF_EN
    chk("bp_ready_c4", 64'(InReady), 64'd0);
`else
    chk("bp_ready_c4", 64'(InReady), 64'd1);
`endif
    next_edge();
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("bp_b_out", 64'({OutValid, w_out}), 64'({1'b1, m_b}));
    next_edge();
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("bp_drained", 64'(OutValid), 64'd0);
    next_edge();

    // Randomized traffic with random stalls against the reference model.
    for (int n = 0; n < 600; n++) begin
      iv    = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 3) != 0);
      rs    = 1'($urandom_range(0, 1));
      rword = $urandom;
      case ($urandom_range(0, 5))
        0:       rraw = 28'd0;
        1:       rraw = 28'h8000000 | 28'(rword);
        default: rraw = 28'(rword >> $urandom_range(4, 31));
      endcase
      if ($urandom_range(0, 1) == 0) re = 8'($urandom_range(0, 30));
      else                           re = 8'($urandom_range(0, 255));
      cyc(iv, rraw, re, rs, ordy);
      score();
      next_edge();
    end
    for (int n = 0; n < 6; n++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
      score();
      next_edge();
    end
    chk("rand_drain_empty", 64'(q.size()), 64'd0);

    // Asynchronous reset while a result is held.
    m_c = model(28'h0123456, 8'd90, 1'b1);
    cyc(1'b1, 28'h4000006, 8'd127, 1'b1, 1'b0);
    next_edge();
    InValid  = 1'b0;
    OutReady = 1'b0;
    #1;
    chk("rst_pre_valid", 64'(OutValid), 64'd1);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("rst_async_clear", 64'({OutValid, w_out}), 64'd0);
    #4;
    Reset_n = 1'b1;
    next_edge();
    cyc(1'b1, 28'h0123456, 8'd90, 1'b1, 1'b1);
    chk("rst_post_idle", 64'(OutValid), 64'd0);
    next_edge();
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("rst_post_first", 64'({OutValid, w_out}), 64'({1'b1, m_c}));
    next_edge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_addsub_normalize_stage.md
Name: fp_addsub_normalize_stage

Overview:
- Pipeline stage 4 of the floating-point add/sub datapath.
- Takes the raw aligned sum or difference from the mantissa adder stage and normalizes it: right-shift on carry-out, or left-shift by the leading-zero count.
- Adjusts the exponent, accumulates sticky, and makes the round-to-nearest-even decision.
- Registers the result behind a valid/ready handshake. It directly feeds the rounding stage's TobeRounded, Round and ExponentAdderResult1 inputs.

Parameters:
- FractionSize, 23, fraction width
- MantissaSize, FractionSize+1, hidden bit plus fraction
- RawSize, MantissaSize+4, carry + mantissa + guard + round + sticky
- ExponentSize, 8, biased exponent width

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- InValid  input  1  RawSum/ExponentIn/SignIn valid
- InReady  output  1  stage can accept this cycle
- RawSum  input  RawSize  [27]=carry, [26:3]=mantissa, [2]=G, [1]=R, [0]=S
- ExponentIn  input  ExponentSize  exponent before normalization
- SignIn  input  1  result sign
- OutValid  output  1  registered outputs valid
- OutReady  input  1  downstream accepts
- TobeRounded  output  MantissaSize  normalized mantissa
- Round  output  1  round-increment decision
- ExponentAdderResult1  output  ExponentSize  adjusted exponent
- SignOut  output  1  registered sign
- Zero, Underflow, Overflow  output  1 each  result flags

Behaviour:
- Clock and reset: one clock, Clk. Reset_n is asynchronous and active-low. While Reset_n is low, every output register is 0, and OutValid=0. Reset mid-transfer discards the held result.
- Handshake and latency:
  - Transfer occurs on a rising edge with InValid & InReady.
  - Latency is 1 cycle: the result appears on the outputs on that edge.
  - InReady = !OutValid | OutReady (combinational).
  - While OutValid & !OutReady, all outputs hold stable.
  - OutValid clears on an OutReady edge with no new input.
  - Simultaneous consume and accept: the register is reloaded and OutValid stays 1.
- Normalization: combinational, evaluated before the register.
  - Zero case: RawSum==0 gives Zero=1, TobeRounded=0, exponent 0, Round=0, Underflow=0.
  - Carry case: RawSum[27]=1.
    - Shift right 1. New S = old R | old S.
    - Exponent = ExponentIn+1.
    - If the result is 255: Overflow=1, and the exponent is forced to 255.
  - Otherwise: lz = leading zeros of RawSum[26:0], range 0..26.
    - If lz < ExponentIn: shift left lz; exponent = ExponentIn-lz.
    - Else (denormal): shift left max(ExponentIn-1, 0); exponent = 0; Underflow=1.
    - Zero fill on the left shift.
- Rounding decision (RNE): after the shift, L=[3], G=[2], R=[1], S=[0].
  - Round = G & (R | S | L).
  - TobeRounded = shifted[26:3].
  - If Overflow=1, Round is forced to 0.
- SignIn passes through the register unchanged. On Zero, SignOut = SignIn & (ExponentIn==0) is not applied; the sign is passed as given.

Optional Feature:
- Macro: NORM_SKID_BUF_EN.
- When defined:
  - A one-entry skid buffer is added, and InReady becomes a registered signal equal to "skid buffer empty".
  - An input accepted while the output is stalled lands in the skid buffer. It moves to the output register on the next OutReady edge.
  - Throughput stays 1/cycle, and ordering is preserved.
  - Reset clears the skid buffer.
- When undefined: single register, with the combinational InReady above.

Test Plan:
- Carry path: RawSum=28'h8000000, ExponentIn=127, OutReady=1 -> one cycle later: OutValid=1, TobeRounded=24'h800000, Round=0, Exp=128, flags 0.
- Left normalize: RawSum=28'h0000008, ExponentIn=100 -> TobeRounded=24'h800000, Exp=77, Round=0. With RawSum=28'h0000000 -> Zero=1, Exp=0.
- RNE:
  - RawSum=28'h4000004 (tie, L=0) -> Round=0, TobeRounded=24'h800000.
  - RawSum=28'h400000C (tie, L=1) -> Round=1, TobeRounded=24'h800001.
  - RawSum=28'h4000006 -> Round=1.
- Denormal and overflow:
  - RawSum=28'h0000008, ExponentIn=5 -> shift 4, TobeRounded=24'h000010, Exp=0, Underflow=1.
  - RawSum=28'h8000000, ExponentIn=254 -> Exp=255, Overflow=1, Round=0.
- Backpressure: offer A then B every cycle, OutReady=0 for 3 cycles.
  - A is held stable and InReady=0, so B waits (with NORM_SKID_BUF_EN: B in skid, InReady=0).
  - OutReady=1 -> A consumed, then B. No loss or duplication.
- Reset mid-op: Reset_n low for half a cycle while OutValid=1, asynchronous to Clk -> all outputs 0 immediately. After release, the first accepted input appears 1 cycle later.
